mux_word_serializer: RTL
========================

Name: mux_word_serializer

Overview:
- Parallel-to-serial front end that sits directly upstream of the 32:1 mux path.
- Accepts a 32-bit word over a valid/ready handshake and holds it in a register.
- Sweeps a 5-bit select counter across all bit positions and emits the selected bit each accepted cycle.
- Emits one bit per accepted beat, with a last flag and a ready-based stall, so a downstream bit consumer can pause it.

Parameters:
- WIDTH, 32: word width in bits; must be a power of 2 and at least 2.
- SEL_W, 5: select counter width; must equal log2(WIDTH).
- MSB_FIRST, 0: 0 emits bit 0 first (ascending select); 1 emits bit WIDTH-1 first (descending select).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  word to serialize; sampled only on accept.
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  downstream accepts the current bit.
- out_bit  output  1  held word indexed by out_sel.
- out_sel  output  SEL_W  current select index.
- out_last  output  1  current bit is the final bit of the word.
- busy  output  1  a word is held and not yet fully emitted.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, word register=0, select counter=0.
  - out_valid=0, busy=0, out_last=0, in_ready=1 once reset releases.
- Reset asserted mid-word discards the held word immediately; no further bits are emitted.
- States: IDLE and SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - in_accept = in_valid & in_ready.
  - On in_accept: capture in_data; set select to 0 (MSB_FIRST=0) or WIDTH-1 (MSB_FIRST=1); go to SEND.
  - Latency from accept edge to first out_valid is one cycle.
- SEND:
  - out_valid=1, busy=1.
  - out_bit = word[out_sel], combinational from registered word and select (registered-select 32:1 mux).
  - out_last=1 when select equals the final index: WIDTH-1 if ascending, 0 if descending.
- out_accept = out_valid & out_ready.
  - If accepted and not last: select steps by 1 (+1 ascending, -1 descending).
  - If accepted and last: see zero-bubble and end-of-word rules below.
- Stall: with out_ready=0, out_bit, out_sel, out_last and out_valid all hold stable; the select counter does not move.
- Zero-bubble chaining: in_ready = (state==IDLE) | (state==SEND & out_last & out_ready).
  - If in_valid is high in the same cycle the last bit is accepted, the new word is captured, the select reloads to its start index, and the block stays in SEND.
  - The first bit of the new word appears on the next cycle with no idle gap.
- End of word: last bit accepted with no new word goes to IDLE; out_valid=0 and busy=0 the next cycle.
- Input rules: in_data is ignored when no accept occurs; in_valid high during SEND (not last) is simply back-pressured.
- Arithmetic: the select counter is SEL_W bits and never wraps past the final index; it is always reloaded at word start.
- Output count: exactly WIDTH out_accept beats per accepted word, no more and no fewer.

Test Plan:
1. Reset and idle: hold rst_n=0 for 2 cycles, then release -> out_valid=0, busy=0, in_ready=1, out_sel=0; pulse rst_n low asynchronously mid-cycle during SEND -> out_valid drops immediately.
2. LSB-first word, MSB_FIRST=0:
   - Stimulus: send in_data=32'h865346BD, out_ready held 1.
   - Response: 32 beats on consecutive cycles; out_bit sequence starts 1,0,1,1 (nibble D) and ends with bit31=1.
   - out_last high only when out_sel=31; then IDLE.
3. Back-pressure:
   - Stimulus: same word, with out_ready toggled 1,0,0,1 repeatedly.
   - Response: out_bit/out_sel frozen during low cycles; still exactly 32 accepted beats matching the scenario 2 sequence.
4. MSB-first build, MSB_FIRST=1:
   - Stimulus: in_data=32'h865346BD.
   - Response: out_sel runs 31 down to 0; first bits are 1,0,0,0,0,1,1,0 (nibbles 8 then 6); out_last at out_sel=0.
5. Zero-bubble chaining:
   - Stimulus: present 32'hFFFFFFFF, then keep in_valid high with 32'h00000000 so it is accepted on the last-bit cycle.
   - Response: bit 32 (final 1) is followed on the next cycle by out_bit=0 with out_sel=0; no cycle with out_valid=0; busy stays 1.
6. Ignored input: toggle in_valid and in_data during SEND before the last bit -> no capture occurs and the current word's bits are unaffected.

Source files
------------

// File: rtl/mux_word_serializer_if.sv
// mux_word_serializer_if: word-in / bit-out handshake bundle for the serializer
// master drives in_valid, in_data and out_ready; slave (the serializer) drives
// in_ready, out_valid, out_bit, out_sel, out_last and busy.
interface mux_word_serializer_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_bit;
    logic [SEL_W-1:0] out_sel;
    logic             out_last;
    logic             busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_bit, out_sel, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_bit, out_sel, out_last, busy
    );
endinterface

// File: rtl/mux_word_serializer.sv
// mux_word_serializer: holds a word and emits it one bit per accepted beat via a registered-select mux
// Ports: clk, rst_n (async active-low); bus.in_* accepts a word, bus.out_* emits
// out_bit = word[out_sel] with out_last on the final index; busy while a word is held.
module mux_word_serializer #(
    parameter int WIDTH     = 32,
    parameter int SEL_W     = 5,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mux_word_serializer_if.slave   bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;
    localparam logic [SEL_W-1:0] FIRST = MSB_FIRST ? SEL_W'(WIDTH - 1) : '0;
    localparam logic [SEL_W-1:0] FINAL = MSB_FIRST ? '0 : SEL_W'(WIDTH - 1);

    logic [0:0]       state;
    logic [WIDTH-1:0] word;
    logic [SEL_W-1:0] sel;
    logic             in_accept;
    logic             out_accept;

    assign bus.out_valid = state == SEND;
    assign bus.busy      = state == SEND;
    assign bus.out_last  = state == SEND && sel == FINAL;
    assign bus.out_bit   = word[sel];
    assign bus.out_sel   = sel;
    // accepting on the last-bit cycle lets the next word follow with no idle gap
    assign bus.in_ready  = state == IDLE || (bus.out_last && bus.out_ready);
    assign in_accept     = bus.in_valid && bus.in_ready;
    assign out_accept    = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            word  <= '0;
            sel   <= '0;
        end else if (in_accept) begin
            state <= SEND;
            word  <= bus.in_data;
            sel   <= FIRST;
        end else if (out_accept) begin
            state <= bus.out_last ? IDLE : SEND;
            sel   <= bus.out_last ? sel : (MSB_FIRST ? sel - SEL_W'(1) : sel + SEL_W'(1));
        end
    end
endmodule
